// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipe_stage_skid instance: upstream (in_*) and downstream (out_*) sides.
// The stage itself binds to the slave modport; the environment driving it uses master.
interface pipe_stage_skid_if #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 52
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush and a saturating stall counter.
// in_ready depends only on registered state, so no combinational path runs from out_ready to in_ready.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 52,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_skid_if.slave bus,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b11;

  logic              main_v;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic [1:0] state;
  logic       accept;
  logic       drain;

  assign state         = {skid_v, main_v};
  assign bus.in_ready  = rst & ~skid_v;
  assign bus.out_valid = main_v;
  assign bus.out_ctrl  = main_v ? main_ctrl : '0;
  assign bus.out_data  = main_data;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = main_v & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v    <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_v    <= 1'b0;
      skid_ctrl <= '0;
      skid_data <= '0;
      stall_cnt <= '0;
    end else begin
      if (main_v && !bus.out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);

      // Flush only drops the valid bits; data registers keep their contents.
      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else begin
        case (state)
          S_EMPTY: begin
            if (accept) begin
              main_v    <= 1'b1;
              main_ctrl <= bus.in_ctrl;
              main_data <= bus.in_data;
            end
          end
          S_ONE: begin
            if (accept && drain) begin
              main_ctrl <= bus.in_ctrl;
              main_data <= bus.in_data;
            end else if (accept) begin
              skid_v    <= 1'b1;
              skid_ctrl <= bus.in_ctrl;
              skid_data <= bus.in_data;
            end else if (drain) begin
              main_v <= 1'b0;
            end
          end
          S_FULL: begin
            if (drain) begin
              skid_v    <= 1'b0;
              main_ctrl <= skid_ctrl;
              main_data <= skid_data;
            end
          end
          default: begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, hand sequences, and random traffic
// against a queue-based reference model. A second instance with a 3-bit counter shares the stimulus.
module tb_pipe_stage_skid;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned DATA_W = 52;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic [7:0] stall_cnt;
  logic [2:0] stall_cnt3;

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus3 ();

  assign bus3.in_valid  = bus.in_valid;
  assign bus3.in_ctrl   = bus.in_ctrl;
  assign bus3.in_data   = bus.in_data;
  assign bus3.out_ready = bus.out_ready;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .flush(flush), .stall_cnt(stall_cnt3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 2 whose head is visible on the outputs.
  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t             mq[$];
  logic [DATA_W-1:0] m_last = '0;
  int                m_cnt  = 0;
  int                m_cnt3 = 0;

  task automatic model_edge();
    bit acc, drn;
    beat_t b;
    if (!rst) begin
      mq.delete();
      m_last = '0;
      m_cnt  = 0;
      m_cnt3 = 0;
    end else begin
      if (mq.size() > 0 && !bus.out_ready) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (flush) begin
        mq.delete();
      end else begin
        acc = bus.in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && bus.out_ready;
        if (drn) void'(mq.pop_front());
        if (acc) begin
          b.ctrl = bus.in_ctrl;
          b.data = bus.in_data;
          mq.push_back(b);
        end
      end
      if (mq.size() > 0) m_last = mq[0].data;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".in_ready"},   64'(bus.in_ready),  64'(rst && mq.size() < 2));
    chk({tag, ".out_valid"},  64'(bus.out_valid), 64'(mq.size() > 0));
    chk({tag, ".out_ctrl"},   64'(bus.out_ctrl),  (mq.size() > 0) ? 64'(mq[0].ctrl) : 64'(0));
    chk({tag, ".out_data"},   64'(bus.out_data),  (mq.size() > 0) ? 64'(mq[0].data) : 64'(m_last));
    chk({tag, ".stall_cnt"},  64'(stall_cnt),     64'(m_cnt));
    chk({tag, ".stall_cnt3"}, 64'(stall_cnt3),    64'(m_cnt3));
  endtask

  task automatic drive(input logic r, input logic iv, input logic [CTRL_W-1:0] ic,
                       input logic [DATA_W-1:0] id, input logic fl, input logic ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_ctrl   = ic;
    bus.in_data   = id;
    flush         = fl;
    bus.out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic              r, iv;
    logic [CTRL_W-1:0] ic;
    logic [DATA_W-1:0] id;
    logic              fl, ordy;
    logic              e_irdy, e_ov;
    logic [CTRL_W-1:0] e_oc;
    logic [DATA_W-1:0] e_od;
    logic [7:0]        e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic iv, logic [3:0] ic, logic [51:0] id, logic fl, logic ordy,
                              logic e_irdy, logic e_ov, logic [3:0] e_oc, logic [51:0] e_od, logic [7:0] e_cnt);
    vec_t v;
    v.r = r; v.iv = iv; v.ic = ic; v.id = id; v.fl = fl; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = e_od; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset check, then 8-beat stream with out_ready=1
    vt.push_back(mk(0, 0, 4'h0, 52'h0,  0, 0,  0, 0, 4'h0, 52'h0, 8'd0));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(1, 1, 4'(k + 1), 52'(k + 1), 0, 1,
                      1, (k != 0), (k == 0) ? 4'h0 : 4'(k), (k == 0) ? 52'h0 : 52'(k), 8'd0));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 1,  1, 1, 4'h8, 52'h8,  8'd0));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 1,  1, 0, 4'h0, 52'h8,  8'd0));
    // A, B under a 3-cycle downstream stall
    vt.push_back(mk(1, 1, 4'hA, 52'hA0, 0, 0,  1, 0, 4'h0, 52'h8,  8'd0));
    vt.push_back(mk(1, 1, 4'hB, 52'hB0, 0, 0,  1, 1, 4'hA, 52'hA0, 8'd0));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 0,  0, 1, 4'hA, 52'hA0, 8'd1));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 0,  0, 1, 4'hA, 52'hA0, 8'd2));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 1,  0, 1, 4'hA, 52'hA0, 8'd3));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 1,  1, 1, 4'hB, 52'hB0, 8'd3));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 1,  1, 0, 4'h0, 52'hB0, 8'd3));
    // FULL, then flush with C on the input
    vt.push_back(mk(1, 1, 4'hA, 52'hA0, 0, 0,  1, 0, 4'h0, 52'hB0, 8'd3));
    vt.push_back(mk(1, 1, 4'hB, 52'hB0, 0, 0,  1, 1, 4'hA, 52'hA0, 8'd3));
    vt.push_back(mk(1, 1, 4'hC, 52'hC0, 1, 0,  0, 1, 4'hA, 52'hA0, 8'd4));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 1,  1, 0, 4'h0, 52'hA0, 8'd5));
    vt.push_back(mk(1, 0, 4'h0, 52'h0,  0, 1,  1, 0, 4'h0, 52'hA0, 8'd5));

    drive(0, 0, '0, '0, 0, 0);
    edge_step();

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].iv, vt[i].ic, vt[i].id, vt[i].fl, vt[i].ordy);
      chk($sformatf("vec%0d.in_ready", i),  64'(bus.in_ready),  64'(vt[i].e_irdy));
      chk($sformatf("vec%0d.out_valid", i), 64'(bus.out_valid), 64'(vt[i].e_ov));
      chk($sformatf("vec%0d.out_ctrl", i),  64'(bus.out_ctrl),  64'(vt[i].e_oc));
      chk($sformatf("vec%0d.out_data", i),  64'(bus.out_data),  64'(vt[i].e_od));
      chk($sformatf("vec%0d.stall_cnt", i), 64'(stall_cnt),     64'(vt[i].e_cnt));
      edge_step();
    end

    // Counter saturation on the 3-bit instance, then flush must not clear it
    drive(0, 0, '0, '0, 0, 0);
    edge_step();
    drive(1, 1, 4'hD, 52'hD0, 0, 0);
    edge_step();
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, '0, '0, 0, 0);
      edge_step();
    end
    drive(1, 0, '0, '0, 0, 0);
    chk("sat.stall_cnt3", 64'(stall_cnt3), 64'd7);
    chk("sat.stall_cnt",  64'(stall_cnt),  64'd10);
    edge_step();
    drive(1, 0, '0, '0, 1, 0);
    edge_step();
    drive(1, 0, '0, '0, 0, 0);
    chk("satflush.stall_cnt3", 64'(stall_cnt3),    64'd7);
    chk("satflush.stall_cnt",  64'(stall_cnt),     64'd12);
    chk("satflush.out_valid",  64'(bus.out_valid), 64'd0);
    edge_step();

    // Reset while FULL, with concurrent flush and in_valid
    drive(1, 1, 4'h1, 52'h111, 0, 0);
    edge_step();
    drive(1, 1, 4'h2, 52'h222, 0, 0);
    edge_step();
    drive(1, 0, '0, '0, 0, 0);
    chk("full.in_ready", 64'(bus.in_ready), 64'd0);
    edge_step();
    drive(0, 1, 4'h3, 52'h333, 1, 0);
    chk("rstfull.in_ready_low", 64'(bus.in_ready), 64'd0);
    edge_step();
    drive(0, 1, 4'h3, 52'h333, 1, 0);
    chk("rstfull.in_ready",   64'(bus.in_ready),  64'd0);
    chk("rstfull.out_valid",  64'(bus.out_valid), 64'd0);
    chk("rstfull.out_ctrl",   64'(bus.out_ctrl),  64'd0);
    chk("rstfull.out_data",   64'(bus.out_data),  64'd0);
    chk("rstfull.stall_cnt",  64'(stall_cnt),     64'd0);
    chk("rstfull.stall_cnt3", 64'(stall_cnt3),    64'd0);
    edge_step();
    drive(1, 0, '0, '0, 0, 0);
    chk("postrst.in_ready",  64'(bus.in_ready),  64'd1);
    chk("postrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("postrst.out_data",  64'(bus.out_data),  64'd0);
    edge_step();

    // Random traffic; ready density varies per 250-cycle window
    for (int c = 0; c < 2000; c++) begin
      int unsigned rdy_pct;
      logic [DATA_W-1:0] d;
      rdy_pct = 20 + ((c / 250) % 4) * 25;
      d = {$urandom, $urandom};
      drive($urandom_range(0, 299) != 0,
            $urandom_range(0, 3) != 0,
            CTRL_W'($urandom),
            d,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 99) < rdy_pct);
      model_check($sformatf("rnd%0d", c));
      edge_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register that replaces the fixed-width inter-stage latches between the pipeline stages. Each instance carries a configurable control field and a configurable data payload. Transfers use a valid/ready handshake backed by a 2-entry skid buffer, so a downstream stall never drops a beat and never needs a combinational ready path back to the upstream stage. Also provides a synchronous flush, bubble control squashing and a saturating stall counter for performance debug.

## Interface
Parameters:
- CTRL_W, 4: width of the control field (RegWrite, MemtoReg, PCS, ...); forced to 0 on bubbles.
- DATA_W, 52: width of the payload (write-reg index, npc, mem, alu, ... concatenated); not cleared on bubbles.
- CNT_W, 8: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous squash of all held and incoming beats.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control field of head beat; 0 when out_valid=0.
- out_data  out  DATA_W  payload of head beat; holds last value when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

## Operation
- **Storage**
  - Head register (main_v, main_ctrl, main_data) drives the outputs.
  - Skid register (skid_v, skid_ctrl, skid_data) holds at most one extra beat.
- **Handshake**
  - Accept event: in_valid & in_ready.
  - Drain event: out_valid & out_ready.
  - in_ready = rst & ~skid_v. It depends only on state, never on out_ready.
  - out_valid = main_v.
  - out_ctrl = main_v ? main_ctrl : 0.
- **State machine**, encoded by {skid_v, main_v}:
  - EMPTY (00):
    - accept → ONE; head loads input.
  - ONE (01):
    - accept & drain → ONE; head loads input.
    - accept & ~drain → FULL; skid loads input.
    - drain & ~accept → EMPTY.
    - neither → ONE, hold.
  - FULL (11): in_ready=0, so no accept is possible.
    - drain → ONE; head loads skid.
    - no drain → FULL, hold.
  - State 10 is illegal. If it is ever reached, recover to EMPTY on the next edge.
- **Ordering**: strict FIFO. A beat is never duplicated, reordered or lost except by flush.
- **Flush** has priority over all other events.
  - Next state is EMPTY.
  - Any beat accepted in the flush cycle is discarded; upstream treats it as consumed.
  - A drain in the flush cycle still completes; the downstream consumes that beat this cycle.
  - Data registers are left unchanged.
- **Stall counter**
  - Increments each cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W−1.
  - Not cleared by flush.
- **Reset** (rst=0 at an edge), regardless of state or concurrent flush/handshake:
  - main_v=0, skid_v=0.
  - All ctrl and data registers = 0.
  - stall_cnt = 0.
  - in_ready=0 while rst=0.
  - After reset: out_valid=0, out_ctrl=0, out_data=0.

## Timing
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N. The downstream can drain it at edge N+1.
- Throughput: 1 beat/cycle sustained when out_ready=1 continuously.
- Stall absorption:
  - Upstream sees in_ready fall one cycle after the first stalled accept (the skid absorbs that beat).
  - in_ready returns to 1 the cycle after the drain from FULL.
- in_ready=1 in the first cycle with rst=1 after reset.
- A flush asserted at edge N gives out_valid=0 and in_ready=1 after edge N.
- Mid-operation reset discards all held beats identically to flush, and also clears data and the counter.

## Test plan
- Reset, then stream 8 beats data=0x1..0x8 with out_ready=1 → outputs 0x1..0x8 on consecutive cycles, 1-cycle latency, in_ready stays 1, stall_cnt=0.
- Send A, B with out_ready=0 for 3 cycles, then out_ready=1:
  - in_ready drops after B is accepted.
  - A then B emerge in order.
  - stall_cnt=3; in_ready=1 the cycle after A drains.
- FULL (A head, B skid), assert flush with in_valid=1 (C) → out_valid=0 next cycle, C never appears, out_ctrl=0, out_data still A.
- Random valid/ready toggling for 2000 cycles with a scoreboard → exact FIFO order, no loss, out_ctrl=0 whenever out_valid=0.
- CNT_W=3, out_valid held with out_ready=0 for 10 cycles → stall_cnt saturates at 7. Then flush → stall_cnt stays 7.
- Assert rst=0 in FULL with simultaneous flush and in_valid → all outputs 0, stall_cnt=0, in_ready=0 during reset and 1 on the first cycle after.
